// File: rtl/vga_pkg.sv
// Screen codes shared by the game flow controller and the screen selector,
// plus the PS/2 make codes the controller reacts to.
package vga_pkg;

   typedef enum logic [1:0] {
      START    = 2'd0,
      GAME     = 2'd1,
      PLAYER_1 = 2'd2,
      PLAYER_2 = 2'd3
   } screen_t;

   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_ESC   = 8'h76;
   localparam logic [7:0] KEY_BREAK = 8'hF0;

endpackage

// File: rtl/key_event_detect.sv
// Pulses evt in the cycle a new keycode ending in `key` appears (break codes excluded).
// Combinational output from a one-register history of the keycode.
module key_event_detect
   import vga_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] keycode,
   input  logic [7:0]  key,
   output logic        evt
);

   logic [15:0] keycode_q;

   // Reset also captures the live keycode so a stale value is not seen as new.
   always_ff @(posedge clk) begin
      if (rst) keycode_q <= keycode;
      else     keycode_q <= keycode;
   end

   assign evt = (keycode != keycode_q) &&
                (keycode[7:0] == key) &&
                (keycode[15:8] != KEY_BREAK);

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: START -> GAME -> win screen -> START, with a score-clear pulse per new game.
// All outputs registered; inputs take effect on the edge that first samples them.
module game_state_ctrl
   import vga_pkg::*;
#(
   parameter logic [4:0] WIN_POINTS  = 5'd10,
   parameter int         HOLD_CYCLES = 195_000_000,
   parameter int         CNT_W       = 28
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] keycode,
   input  logic [4:0]  points_1,
   input  logic [4:0]  points_2,
   output logic [1:0]  screen,
   output logic        score_clr
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   screen_t          screen_q, screen_d;
   logic             score_clr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             enter_evt, esc_evt;

   key_event_detect u_enter (
      .clk     (clk),
      .rst     (rst),
      .keycode (keycode),
      .key     (KEY_ENTER),
      .evt     (enter_evt)
   );

   key_event_detect u_esc (
      .clk     (clk),
      .rst     (rst),
      .keycode (keycode),
      .key     (KEY_ESC),
      .evt     (esc_evt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         screen_q   <= START;
         score_clr  <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         screen_q   <= screen_d;
         score_clr  <= score_clr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      screen_d    = screen_q;
      score_clr_d = 1'b0;
      hold_cnt_d  = '0;
      case (screen_q)
         START: begin
            if (enter_evt) begin
               screen_d    = GAME;
               score_clr_d = 1'b1;
            end
         end
         GAME: begin
            if (esc_evt)                      screen_d = START;
            else if (points_1 >= WIN_POINTS) screen_d = PLAYER_1;
            else if (points_2 >= WIN_POINTS) screen_d = PLAYER_2;
         end
         PLAYER_1, PLAYER_2: begin
            // Enter beats the timeout when both land in the same cycle.
            if (enter_evt) begin
               screen_d    = GAME;
               score_clr_d = 1'b1;
            end else if (hold_cnt_q == HOLD_LAST) begin
               screen_d = START;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: screen_d = START;
      endcase
   end

   assign screen = screen_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a short hold time.
module tb_game_state_ctrl;
   import vga_pkg::*;

   localparam int HOLD = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] keycode;
   logic [4:0]  points_1, points_2;
   logic [1:0]  screen;
   logic        score_clr;

   int checks = 0;
   int errors = 0;

   game_state_ctrl #(
      .WIN_POINTS  (5'd10),
      .HOLD_CYCLES (HOLD),
      .CNT_W       (28)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .keycode   (keycode),
      .points_1  (points_1),
      .points_2  (points_2),
      .screen    (screen),
      .score_clr (score_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [15:0] kc;
      logic [4:0]  p1;
      logic [4:0]  p2;
      logic [1:0]  exp_screen;
      logic        exp_clr;
   } vec_t;

   vec_t vecs [$];

   // One cycle: drive on the falling edge, check just after the rising edge.
   task automatic cyc(input logic r, input logic [15:0] kc, input logic [4:0] p1,
                      input logic [4:0] p2, input logic [1:0] es, input logic ec,
                      input string name);
      @(negedge clk);
      rst = r; keycode = kc; points_1 = p1; points_2 = p2;
      @(posedge clk);
      #1;
      checks++;
      if (screen !== es || score_clr !== ec) begin
         errors++;
         $display("FAIL %s at %0t: screen=%0d score_clr=%0b, required screen=%0d score_clr=%0b",
                  name, $time, screen, score_clr, es, ec);
      end
   endtask

   function automatic vec_t mk(logic r, logic [15:0] kc, logic [4:0] p1, logic [4:0] p2,
                               screen_t s, logic c);
      vec_t v;
      v.rst = r; v.kc = kc; v.p1 = p1; v.p2 = p2; v.exp_screen = s; v.exp_clr = c;
      return v;
   endfunction

   initial begin
      rst = 1'b1; keycode = 16'h005A; points_1 = '0; points_2 = '0;

      vecs.push_back(mk(1, 16'h005A, 0,  0,  START,    0));  // reset held
      vecs.push_back(mk(1, 16'h005A, 0,  0,  START,    0));
      vecs.push_back(mk(1, 16'h005A, 0,  0,  START,    0));
      vecs.push_back(mk(0, 16'h005A, 0,  0,  START,    0));  // unchanged key after reset
      vecs.push_back(mk(0, 16'h0000, 0,  0,  START,    0));
      vecs.push_back(mk(0, 16'h005A, 0,  0,  GAME,     1));  // enter -> game, clr pulse
      vecs.push_back(mk(0, 16'h005A, 0,  0,  GAME,     0));
      vecs.push_back(mk(0, 16'h5AF0, 0,  0,  GAME,     0));
      vecs.push_back(mk(0, 16'hF05A, 0,  0,  GAME,     0));  // break code is no event
      vecs.push_back(mk(0, 16'hF05A, 9,  0,  GAME,     0));
      vecs.push_back(mk(0, 16'hF05A, 10, 0,  PLAYER_1, 0));
      vecs.push_back(mk(0, 16'h0000, 10, 0,  PLAYER_1, 0));
      vecs.push_back(mk(0, 16'h005A, 0,  0,  GAME,     1));  // enter from win screen
      vecs.push_back(mk(0, 16'h005A, 10, 10, PLAYER_1, 0));  // tie -> player 1
      vecs.push_back(mk(0, 16'h0000, 0,  0,  PLAYER_1, 0));
      vecs.push_back(mk(0, 16'h005A, 0,  0,  GAME,     1));
      vecs.push_back(mk(0, 16'h0076, 0,  10, START,    0));  // esc beats player 2
      vecs.push_back(mk(0, 16'h0076, 0,  10, START,    0));
      vecs.push_back(mk(0, 16'h0000, 0,  10, START,    0));
      vecs.push_back(mk(0, 16'h005A, 0,  0,  GAME,     1));
      vecs.push_back(mk(0, 16'h005A, 0,  10, PLAYER_2, 0));

      foreach (vecs[i])
         cyc(vecs[i].rst, vecs[i].kc, vecs[i].p1, vecs[i].p2,
             vecs[i].exp_screen, vecs[i].exp_clr, $sformatf("vec%0d", i));

      // Player 2 screen times out exactly HOLD cycles after entry.
      for (int k = 1; k <= HOLD; k++)
         cyc(0, 16'h005A, 0, 10, (k < HOLD) ? PLAYER_2 : START, 0, $sformatf("hold_p2_%0d", k));

      // Enter in the same cycle as the timeout goes to GAME.
      cyc(0, 16'h0000, 0, 0, START, 0, "seqb_idle");
      cyc(0, 16'h005A, 0, 0, GAME, 1, "seqb_start");
      cyc(0, 16'h005A, 10, 0, PLAYER_1, 0, "seqb_win");
      for (int k = 1; k < HOLD; k++)
         cyc(0, 16'h0000, 10, 0, PLAYER_1, 0, $sformatf("seqb_hold_%0d", k));
      cyc(0, 16'h005A, 0, 0, GAME, 1, "enter_at_timeout");
      cyc(0, 16'h005A, 0, 0, GAME, 0, "clr_one_cycle");
      cyc(0, 16'h005A, 10, 0, PLAYER_1, 0, "seqb_rewin");
      for (int k = 1; k <= HOLD; k++)
         cyc(0, 16'h005A, 10, 0, (k < HOLD) ? PLAYER_1 : START, 0, $sformatf("seqb_rehold_%0d", k));

      // Reset mid win screen discards the hold count.
      cyc(0, 16'h0000, 0, 0, START, 0, "seqc_idle");
      cyc(0, 16'h005A, 0, 0, GAME, 1, "seqc_start");
      cyc(0, 16'h005A, 10, 0, PLAYER_1, 0, "seqc_win");
      for (int k = 1; k <= 5; k++)
         cyc(0, 16'h005A, 10, 0, PLAYER_1, 0, $sformatf("seqc_hold_%0d", k));
      cyc(1, 16'h005A, 10, 0, START, 0, "rst_mid_hold");
      cyc(0, 16'h005A, 10, 0, START, 0, "no_evt_after_rst");
      cyc(0, 16'h0000, 0, 0, START, 0, "seqc_idle2");
      cyc(0, 16'h005A, 0, 0, GAME, 1, "seqc_restart");
      cyc(0, 16'h005A, 10, 0, PLAYER_1, 0, "seqc_rewin");
      for (int k = 1; k <= HOLD; k++)
         cyc(0, 16'h005A, 10, 0, (k < HOLD) ? PLAYER_1 : START, 0, $sformatf("seqc_rehold_%0d", k));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
